rkx_ctrl: RTL

- Parametrised successor to the RK8-E IOT front end. Decodes the 67xx IOTs, holds the command, current-address, disk-address and status registers, and sequences one sector operation at a time to a generic storage back end over a req/ack/done handshake.
- Adds features the first-generation controller lacks:
  - configurable drive count and cylinder limit;
  - busy-command rejection;
  - a DMA current-address tracker with field carry;
  - an operation watchdog.
- Sits between the CPU IOT bus and the SD back end.

---
 rtl/rkx_pkg.sv | 21 ++
 rtl/rkx_watchdog.sv | 19 +
 rtl/rkx_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rkx_pkg.sv
// rkx_pkg: shared types and constants for the rkx disk controller.
package rkx_pkg;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_ABORT = 2'd2} op_code_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE, S_DONE} state_e;
  localparam int ST_DONE    = 0;
  localparam int ST_BUSYERR = 5;
  localparam int ST_TIMEERR = 6;
  localparam int ST_WLOCK   = 7;
  localparam int ST_BEERR   = 8;
  localparam int ST_DRVERR  = 10;
  localparam int ST_CYLERR  = 11;
  localparam logic [2:0] FN_NOP  = 3'd0;
  localparam logic [2:0] FN_DSKP = 3'd1;
  localparam logic [2:0] FN_DCLR = 3'd2;
  localparam logic [2:0] FN_DLAG = 3'd3;
  localparam logic [2:0] FN_DLCA = 3'd4;
  localparam logic [2:0] FN_DRST = 3'd5;
  localparam logic [2:0] FN_DLDC = 3'd6;
  localparam logic [2:0] FN_DCLB = 3'd7;
  localparam logic [4:0] F1 = 5'd1;
endpackage

// File: rtl/rkx_watchdog.sv
// rkx_watchdog: loadable down-counter, pulses expire_o as it runs out.
// Ports: clk, reset (sync clear), load_i (reload to TIMEOUT_CYC),
//        run_i (count down), expire_o (one-cycle pulse on reaching zero).
module rkx_watchdog #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);
  logic [23:0] count_q;
  always_ff @(posedge clk)
    if (reset) count_q <= '0;
    else if (load_i) count_q <= TIMEOUT_CYC;
    else if (run_i && count_q != '0) count_q <= count_q - 24'd1;
  assign expire_o = run_i && !load_i && count_q == 24'd1;
endmodule

// File: rtl/rkx_ctrl.sv
// rkx_ctrl: RK8-E style IOT front end sequencing sector ops to a storage back end.
// Ports: clk/reset/clear; CPU side instruction, state, ac, UF -> dev_bus, skip,
//        interrupt; back end op_req/op_code/op_drive/op_dar/op_mem/op_len out,
//        op_ack/op_word/op_done/op_err in.
module rkx_ctrl
  import rkx_pkg::*;
#(
  parameter logic [5:0]  DEV_CODE    = 6'o74,
  parameter int          NUM_DRIVES  = 4,
  parameter logic [7:0]  MAX_CYL     = 8'd202,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [0:11] instruction,
  input  logic [4:0]  state,
  input  logic [0:11] ac,
  input  logic        UF,
  output logic [0:11] dev_bus,
  output logic        skip,
  output logic        interrupt,
  output logic        op_req,
  output logic [1:0]  op_code,
  output logic [1:0]  op_drive,
  output logic [0:12] op_dar,
  output logic [0:14] op_mem,
  output logic        op_len,
  input  logic        op_ack,
  input  logic        op_word,
  input  logic        op_done,
  input  logic        op_err
);
  state_e      fsm_q, fsm_d;
  logic [0:11] status_q, status_d, cmd_q, cmd_d, car_q, car_d, dar_q, dar_d, dev_bus_q, dev_bus_d;
  logic [0:3]  wlock_q, wlock_d;
  logic        skip_q, skip_d, irq_q, abort_q, abort_d, wd_load, wd_expire;
  wire f1  = state == F1 && !UF;
  wire caf = f1 && instruction == 12'o6007;
  wire iot = f1 && instruction[0:2] == 3'o6 && instruction[3:8] == DEV_CODE;
  wire clr = reset || clear || caf;
  wire [2:0] fn = instruction[9:11];
  rkx_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk(clk), .reset(clr), .load_i(wd_load),
    .run_i(fsm_q == S_ISSUE || fsm_q == S_ACTIVE), .expire_o(wd_expire)
  );
  // Abort requests are tracked apart from the FSM so it can move on while the abort drains.
  assign op_req    = fsm_q == S_ISSUE || abort_q;
  assign op_code   = abort_q ? OP_ABORT : cmd_q[0] ? OP_WRITE : OP_READ;
  assign op_drive  = cmd_q[9:10];
  assign op_dar    = {cmd_q[11], dar_q};
  assign op_mem    = {cmd_q[6:8], car_q};
  assign op_len    = cmd_q[5];
  assign dev_bus   = dev_bus_q;
  assign skip      = skip_q;
  assign interrupt = irq_q;
  always_comb begin
    fsm_d     = fsm_q;
    status_d  = status_q;
    cmd_d     = cmd_q;
    car_d     = car_q;
    dar_d     = dar_q;
    wlock_d   = wlock_q;
    dev_bus_d = dev_bus_q;
    skip_d    = f1 ? 1'b0 : skip_q;
    abort_d   = abort_q && !op_ack;
    wd_load   = 1'b0;
    case (fsm_q)
      S_ISSUE:
        if (wd_expire) begin
          status_d[ST_TIMEERR] = 1'b1;
          abort_d = 1'b1;
          fsm_d = S_DONE;
        end else if (op_ack && !abort_q) begin
          fsm_d = S_ACTIVE;
          wd_load = 1'b1;
        end
      S_ACTIVE: begin
        // Word counts before completion so a coincident op_done sees the final address.
        if (op_word) {cmd_d[6:8], car_d} = {cmd_q[6:8], car_q} + 15'd1;
        if (op_done) begin
          status_d[ST_BEERR] = status_q[ST_BEERR] | op_err;
          fsm_d = S_DONE;
        end else if (wd_expire) begin
          status_d[ST_TIMEERR] = 1'b1;
          abort_d = 1'b1;
          fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        status_d[ST_DONE] = 1'b1;
        fsm_d = S_IDLE;
      end
      default: ;
    endcase
    if (iot)
      case (fn)
        FN_DSKP: skip_d = status_q != '0;
        FN_DCLR: begin
          status_d = ac[10:11] == 2'b10 ? 12'o4000 : 12'o0000;
          if (ac[10:11] == 2'b01 && fsm_q == S_ACTIVE) begin
            abort_d = 1'b1;
            fsm_d = S_IDLE;
          end
        end
        FN_DLAG:
          if (fsm_q != S_IDLE) status_d[ST_BUSYERR] = 1'b1;
          else if ({1'b0, cmd_q[9:10]} >= 3'(NUM_DRIVES)) status_d[ST_DRVERR] = 1'b1;
          else if ({cmd_q[11], ac[0:6]} > MAX_CYL) status_d[ST_CYLERR] = 1'b1;
          else if (cmd_q[0:1] == 2'b10 && wlock_q[cmd_q[9:10]]) status_d[ST_WLOCK] = 1'b1;
          else begin
            dar_d = ac;
            if (cmd_q[0:2] == 3'b011 && cmd_q[4]) status_d[ST_DONE] = 1'b1;
            if (!cmd_q[1]) begin
              fsm_d = S_ISSUE;
              wd_load = 1'b1;
            end
          end
        FN_DLCA: car_d = ac;
        FN_DRST: dev_bus_d = status_q;
        FN_DLDC: begin
          cmd_d = ac;
          status_d = ac[4] ? 12'o4000 : 12'o0000;
          if (ac[0:2] == 3'b010) wlock_d[ac[9:10]] = 1'b1;
        end
        FN_DCLB: dev_bus_d = '0;
        default: ;
      endcase
  end
  always_ff @(posedge clk)
    if (clr) begin
      fsm_q     <= S_IDLE;
      status_q  <= '0;
      cmd_q     <= '0;
      car_q     <= '0;
      dar_q     <= '0;
      wlock_q   <= '0;
      dev_bus_q <= '0;
      skip_q    <= 1'b0;
      irq_q     <= 1'b0;
      abort_q   <= caf && !reset && !clear && fsm_q == S_ACTIVE;
    end else begin
      fsm_q     <= fsm_d;
      status_q  <= status_d;
      cmd_q     <= cmd_d;
      car_q     <= car_d;
      dar_q     <= dar_d;
      wlock_q   <= wlock_d;
      dev_bus_q <= dev_bus_d;
      skip_q    <= skip_d;
      irq_q     <= status_q != '0 && cmd_q[3];
      abort_q   <= abort_d;
    end
endmodule
